lsq_unit: RTL

Parametrised load/store unit: issue is decoupled from the data cache by an LSQ_DEPTH-entry in-order queue, with a per-cycle access FSM. Address generation happens at issue. Sub-word loads and stores are aligned onto byte lanes. Misaligned accesses complete as exceptions without touching the cache, and `flush` discards queued work. It sits between the issue stage (operands A/B, ROB slot) and the ROB writeback port, and drives the data-cache master interface.

---
 rtl/lsq_unit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq_unit.sv
// Load/store unit: an in-order issue queue feeding a single-outstanding data-cache
// access FSM, with byte-lane alignment, misalignment exceptions and flush.
package lsq_pkg;
  typedef enum logic [1:0] {LS_BYTE = 2'd0, LS_HALF = 2'd1, LS_WORD = 2'd2} ls_op_t;

  typedef struct packed {
    logic        load_inst;
    logic        store_inst;
    logic [31:0] imm;
    logic        imm_valid;
    ls_op_t      ls_op;
    logic        ls_sext;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic [31:0] pc;
  } dec_inst_t;

  typedef struct packed {
    logic [31:0] result_lo;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
  } rob_entry_t;
endpackage

module lsq_unit
  import lsq_pkg::*;
#(
  parameter int ROB_DEPTHLOG2 = 4,
  parameter int LSQ_DEPTHLOG2 = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  dec_inst_t                inst,
  input  logic                     inst_valid,
  input  logic [31:0]              A,
  input  logic [31:0]              B,
  input  logic [ROB_DEPTHLOG2-1:0] rob_slot,
  input  logic                     flush,
  output logic                     ready,
  output logic                     rob_data_valid,
  output logic [ROB_DEPTHLOG2-1:0] rob_data_idx,
  output rob_entry_t               rob_data,
  output logic                     rob_data_exc,
  output logic                     cache_rd,
  output logic                     cache_wr,
  output logic [31:0]              cache_addr,
  output logic [31:0]              cache_wr_data,
  output logic [3:0]               cache_wr_be,
  input  logic [31:0]              cache_data,
  input  logic                     cache_waitrequest
);
  localparam int LSQ_DEPTH = 2 ** LSQ_DEPTHLOG2;
  localparam logic [LSQ_DEPTHLOG2:0] PTR_ONE = 1;

  typedef struct packed {
    logic [31:0]              addr;
    logic [31:0]              data;
    ls_op_t                   ls_op;
    logic                     ls_sext;
    logic                     load;
    logic                     store;
    logic [4:0]               dest_reg;
    logic                     dest_reg_valid;
    logic [31:0]              pc;
    logic [ROB_DEPTHLOG2-1:0] rob_slot;
  } entry_t;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  function automatic logic misaligned(entry_t e);
    return (e.load | e.store) &&
           ((e.ls_op == LS_HALF && e.addr[0]) || (e.ls_op == LS_WORD && e.addr[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] lane_data(entry_t e);
    case (e.ls_op)
      LS_BYTE: return {4{e.data[7:0]}};
      LS_HALF: return {2{e.data[15:0]}};
      default: return e.data;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(entry_t e);
    case (e.ls_op)
      LS_BYTE: return 4'b0001 << e.addr[1:0];
      LS_HALF: return e.addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_value(entry_t e, logic [31:0] raw);
    logic [31:0] s;
    s = raw >> {e.addr[1:0], 3'b000};
    case (e.ls_op)
      LS_BYTE: return e.ls_sext ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
      LS_HALF: return e.ls_sext ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  entry_t                   mem_q [LSQ_DEPTH];
  entry_t                   new_e, head_e, next_e, start_e, wb_e;
  state_t                   state_q, state_d;
  logic [LSQ_DEPTHLOG2:0]   head_q, head_d, tail_q, tail_d, head_next;
  logic                     flushed_q, flushed_d;
  logic                     cache_rd_q, cache_rd_d, cache_wr_q, cache_wr_d;
  logic [31:0]              cache_addr_q, cache_addr_d, cache_wr_data_q, cache_wr_data_d;
  logic [3:0]               cache_wr_be_q, cache_wr_be_d;
  logic                     rob_data_valid_q, rob_data_valid_d, rob_data_exc_q, rob_data_exc_d;
  logic [ROB_DEPTHLOG2-1:0] rob_data_idx_q, rob_data_idx_d;
  rob_entry_t               rob_data_q, rob_data_d;
  logic                     empty, full, accept, start_req, wb_req, wb_exc;
  logic [31:0]              wb_result;

  assign empty     = (head_q == tail_q);
  assign full      = (head_q[LSQ_DEPTHLOG2-1:0] == tail_q[LSQ_DEPTHLOG2-1:0]) &&
                     (head_q[LSQ_DEPTHLOG2] != tail_q[LSQ_DEPTHLOG2]);
  assign ready     = ~full;
  assign accept    = inst_valid & ready & ~flush;
  assign head_next = head_q + PTR_ONE;
  assign head_e    = mem_q[head_q[LSQ_DEPTHLOG2-1:0]];
  assign next_e    = mem_q[head_next[LSQ_DEPTHLOG2-1:0]];

  always_comb begin
    new_e                = '0;
    new_e.addr           = A + (inst.imm_valid ? inst.imm : 32'd0);
    new_e.data           = B;
    new_e.ls_op          = inst.ls_op;
    new_e.ls_sext        = inst.ls_sext;
    new_e.load           = inst.load_inst;
    new_e.store          = inst.store_inst;
    new_e.dest_reg       = inst.dest_reg;
    new_e.dest_reg_valid = inst.dest_reg_valid;
    new_e.pc             = inst.pc;
    new_e.rob_slot       = rob_slot;
  end

  // NOTE: queue storage is written only on accept and never reset; the head/tail
  // pointers alone define which entries are live, so stale contents are harmless.
  always_ff @(posedge clock) begin
    if (accept) mem_q[tail_q[LSQ_DEPTHLOG2-1:0]] <= new_e;
  end

  // NOTE: every *_d gets a default before any branch so no path infers a latch.
  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    state_d          = state_q;
    flushed_d        = flushed_q;
    cache_rd_d       = cache_rd_q;
    cache_wr_d       = cache_wr_q;
    cache_addr_d     = cache_addr_q;
    cache_wr_data_d  = cache_wr_data_q;
    cache_wr_be_d    = cache_wr_be_q;
    rob_data_valid_d = 1'b0;
    rob_data_idx_d   = rob_data_idx_q;
    rob_data_d       = rob_data_q;
    rob_data_exc_d   = rob_data_exc_q;
    start_req        = 1'b0;
    start_e          = head_e;
    wb_req           = 1'b0;
    wb_e             = head_e;
    wb_exc           = 1'b0;
    wb_result        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty && !flush) begin
          if ((head_e.load | head_e.store) && !misaligned(head_e)) begin
            start_req = 1'b1;
            state_d   = S_ACCESS;
          end else begin
            // Misaligned or non-memory ops retire straight from the queue.
            head_d    = head_next;
            wb_req    = 1'b1;
            wb_exc    = misaligned(head_e);
            wb_result = wb_exc ? head_e.addr : 32'd0;
          end
        end
      end
      S_ACCESS: begin
        if (flush) flushed_d = 1'b1;
        if (!cache_waitrequest) begin
          cache_rd_d = 1'b0;
          cache_wr_d = 1'b0;
          state_d    = S_IDLE;
          flushed_d  = 1'b0;
          // A flushed access already gave up its slot when tail was pulled back to head.
          if (!flush && !flushed_q) begin
            head_d    = head_next;
            wb_req    = 1'b1;
            wb_result = head_e.load ? load_value(head_e, cache_data) : 32'd0;
            if (head_next != tail_q && (next_e.load | next_e.store) && !misaligned(next_e)) begin
              start_req = 1'b1;
              start_e   = next_e;
              state_d   = S_ACCESS;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_req) begin
      cache_rd_d      = start_e.load;
      cache_wr_d      = start_e.store;
      cache_addr_d    = {start_e.addr[31:2], 2'b00};
      cache_wr_data_d = start_e.store ? lane_data(start_e) : 32'd0;
      cache_wr_be_d   = start_e.store ? lane_be(start_e) : 4'b0000;
    end

    if (wb_req) begin
      rob_data_valid_d          = 1'b1;
      rob_data_idx_d            = wb_e.rob_slot;
      rob_data_exc_d            = wb_exc;
      rob_data_d.result_lo      = wb_result;
      rob_data_d.dest_reg       = wb_e.dest_reg;
      rob_data_d.dest_reg_valid = wb_e.dest_reg_valid & ~wb_e.store;
    end

    if (flush)       tail_d = head_q;
    else if (accept) tail_d = tail_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignment only; the comb block above
  // uses blocking assignment so later lines see earlier defaults.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      head_q           <= '0;
      tail_q           <= '0;
      flushed_q        <= 1'b0;
      cache_rd_q       <= 1'b0;
      cache_wr_q       <= 1'b0;
      cache_addr_q     <= '0;
      cache_wr_data_q  <= '0;
      cache_wr_be_q    <= '0;
      rob_data_valid_q <= 1'b0;
      rob_data_idx_q   <= '0;
      rob_data_q       <= '0;
      rob_data_exc_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      flushed_q        <= flushed_d;
      cache_rd_q       <= cache_rd_d;
      cache_wr_q       <= cache_wr_d;
      cache_addr_q     <= cache_addr_d;
      cache_wr_data_q  <= cache_wr_data_d;
      cache_wr_be_q    <= cache_wr_be_d;
      rob_data_valid_q <= rob_data_valid_d;
      rob_data_idx_q   <= rob_data_idx_d;
      rob_data_q       <= rob_data_d;
      rob_data_exc_q   <= rob_data_exc_d;
    end
  end

  assign cache_rd       = cache_rd_q;
  assign cache_wr       = cache_wr_q;
  assign cache_addr     = cache_addr_q;
  assign cache_wr_data  = cache_wr_data_q;
  assign cache_wr_be    = cache_wr_be_q;
  assign rob_data_valid = rob_data_valid_q;
  assign rob_data_idx   = rob_data_idx_q;
  assign rob_data       = rob_data_q;
  assign rob_data_exc   = rob_data_exc_q;
endmodule
